// File: rtl/mem_if.sv
// mem_if: word-addressed data-memory request/acknowledge bus.
//   mem_req   - initiator requests an access (held until mem_ack)
//   mem_we    - 1 = write, 0 = read; valid while mem_req
//   mem_addr  - word address; valid while mem_req
//   mem_wdata - write data; valid while mem_req && mem_we
//   mem_ack   - memory completes the request (sampled on clk)
//   mem_rdata - read data, valid when mem_ack && !mem_we
// master = processor side, slave = memory side.
interface mem_if #(
   parameter int AW = 10
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack;
   logic [31:0]   mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_ack, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_request_unit.sv
// mem_request_unit: processor-side initiator for data-memory accesses.
// Holds the pipeline while a load/store is outstanding on the mem_if bus,
// returns the loaded word, and flags misaligned, load+store conflicting
// and timed-out accesses.
//   clk, rst         - clock, synchronous active-high reset
//   isLd, isSt       - current instruction is a load / store
//   aluResult, op2   - byte address / store data
//   stall            - hold pipeline this cycle
//   ldResult         - registered load data (0 for stores and faults)
//   ldValid, err     - one-cycle completion pulse, with fault flag
//   mem              - memory request bus (master side)
module mem_request_unit #(
   parameter int TIMEOUT = 15,
   parameter int AW      = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        isLd,
   input  logic        isSt,
   input  logic [31:0] aluResult,
   input  logic [31:0] op2,
   output logic        stall,
   output logic [31:0] ldResult,
   output logic        ldValid,
   output logic        err,
   mem_if.master       mem
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   // Counter value during the last REQ cycle allowed before abort; with the
   // counter cleared on REQ entry, mem_req is high for exactly TIMEOUT cycles.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [7:0]    cnt_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic          flag_q;     // fault to report with the coming ldValid

   logic access, aligned, expired;
   logic unused_hi;

   assign access    = isLd | isSt;
   assign aligned   = (aluResult[1:0] == 2'b00);
   assign expired   = (cnt_q == TO_LAST);
   assign unused_hi = ^aluResult[31:AW+2];

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      ldValid     = 1'b0;
      err         = 1'b0;
      mem.mem_req = 1'b0;
      case (state_q)
         IDLE: begin
            // Combinational so the requesting instruction stalls in its first cycle.
            if (access) begin
               stall   = 1'b1;
               state_d = aligned ? REQ : DONE;
            end
         end
         REQ: begin
            stall       = 1'b1;
            mem.mem_req = 1'b1;
            if (mem.mem_ack || expired) state_d = DONE;
         end
         DONE: begin
            ldValid = 1'b1;
            err     = flag_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         flag_q   <= 1'b0;
         ldResult <= '0;
      end else begin
         case (state_q)
            IDLE: if (access) begin
               cnt_q <= '0;
               if (aligned) begin
                  // Store wins when both are set; the conflict is still reported.
                  we_q    <= isSt;
                  addr_q  <= aluResult[AW+1:2];
                  wdata_q <= op2;
                  flag_q  <= isLd & isSt;
               end else begin
                  flag_q   <= 1'b1;
                  ldResult <= '0;
               end
            end
            REQ: begin
               cnt_q <= cnt_q + 8'd1;
               if (mem.mem_ack) begin
                  ldResult <= we_q ? 32'd0 : mem.mem_rdata;
               end else if (expired) begin
                  ldResult <= '0;
                  flag_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_request_unit.sv
module tb_mem_request_unit;
   localparam int TIMEOUT = 15;
   localparam int AW      = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        isLd = 1'b0, isSt = 1'b0;
   logic [31:0] aluResult = '0, op2 = '0;
   logic        stall, ldValid, err;
   logic [31:0] ldResult;

   mem_if #(.AW(AW)) bus ();

   mem_request_unit #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
      .clk(clk), .rst(rst), .isLd(isLd), .isSt(isSt),
      .aluResult(aluResult), .op2(op2), .stall(stall),
      .ldResult(ldResult), .ldValid(ldValid), .err(err), .mem(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int          stall_n;
      int          req_n;
      logic        valid;
      logic        err;
      logic        we;
      logic        unstable;
      logic        stray;
      logic [31:0] res;
      logic [31:0] wdata;
      logic [AW-1:0] addr;
   } res_t;

   typedef struct {
      logic        ld, st;
      logic [31:0] a, d;
      int          k;          // ack in k-th REQ cycle, 0 = never
      logic [31:0] rd;
      res_t        e;
   } vec_t;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // Reference: outcome of one access from the behavioural rules.
   function automatic res_t model(input logic ld, st, input logic [31:0] a, d,
                                  input int k, input logic [31:0] rd);
      res_t m;
      logic to;
      m = '0;
      m.valid = 1'b1;
      if (a[1:0] != 2'b00) begin
         m.stall_n = 1;
         m.err     = 1'b1;
      end else begin
         to        = (k == 0) || (k > TIMEOUT);
         m.req_n   = to ? TIMEOUT : k;
         m.stall_n = 1 + m.req_n;
         m.err     = to || (ld && st);
         m.res     = (to || st) ? 32'd0 : rd;
         m.we      = st;
         m.addr    = a[AW+1:2];
         m.wdata   = d;
      end
      return m;
   endfunction

   // Presents one instruction and plays the memory; returns at the DONE cycle.
   task automatic run_access(input logic ld, st, input logic [31:0] a, d,
                             input int k, input logic [31:0] rd, output res_t r);
      r = '0;
      @(posedge clk); #1;
      isLd = ld; isSt = st; aluResult = a; op2 = d;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (stall) r.stall_n++;
         if (err && !ldValid) r.stray = 1'b1;
         if (bus.mem_req) begin
            if (r.req_n == 0) begin
               r.addr = bus.mem_addr; r.we = bus.mem_we; r.wdata = bus.mem_wdata;
            end else if (bus.mem_addr != r.addr || bus.mem_we != r.we ||
                         bus.mem_wdata != r.wdata) begin
               r.unstable = 1'b1;
            end
            r.req_n++;
            if (r.req_n == k) begin bus.mem_ack = 1'b1; bus.mem_rdata = rd; end
         end
         if (ldValid) begin
            r.valid = 1'b1; r.err = err; r.res = ldResult;
            isLd = 1'b0; isSt = 1'b0;
            break;
         end
         @(posedge clk); #1;
         bus.mem_ack = 1'b0;
         bus.mem_rdata = $urandom;
      end
      bus.mem_ack = 1'b0;
   endtask

   task automatic compare(input string nm, input res_t r, input res_t e);
      chk({nm, ".valid"},  32'(r.valid),    32'(e.valid));
      chk({nm, ".stall"},  r.stall_n,       e.stall_n);
      chk({nm, ".req"},    r.req_n,         e.req_n);
      chk({nm, ".err"},    32'(r.err),      32'(e.err));
      chk({nm, ".res"},    r.res,           e.res);
      chk({nm, ".stray"},  32'(r.stray),    32'(1'b0));
      if (e.req_n > 0) begin
         chk({nm, ".addr"},   32'(r.addr),     32'(e.addr));
         chk({nm, ".we"},     32'(r.we),       32'(e.we));
         chk({nm, ".stable"}, 32'(r.unstable), 32'(1'b0));
         if (e.we) chk({nm, ".wdata"}, r.wdata, e.wdata);
      end
   endtask

   function automatic res_t exp_r(input int s, q, input logic e, input logic [31:0] res,
                                  input logic [AW-1:0] ad, input logic we,
                                  input logic [31:0] wd);
      res_t m;
      m = '0;
      m.valid = 1'b1; m.stall_n = s; m.req_n = q; m.err = e; m.res = res;
      m.addr = ad; m.we = we; m.wdata = wd;
      return m;
   endfunction

   vec_t tbl[8];
   res_t r, e;

   initial begin
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;

      tbl[0] = '{1, 0, 32'h10,  0, 1, 32'hDEADBEEF, exp_r(2, 1, 0, 32'hDEADBEEF, 10'h4, 0, 0)};
      tbl[1] = '{1, 0, 32'h6,   0, 1, 32'h77777777, exp_r(1, 0, 1, 0, 0, 0, 0)};
      tbl[2] = '{0, 1, 32'hFFC, 32'h12345678, 3, 32'h99999999,
                 exp_r(4, 3, 0, 0, 10'h3FF, 1, 32'h12345678)};
      tbl[3] = '{1, 0, 32'h44,  0, 15, 32'hCAFEF00D, exp_r(16, 15, 0, 32'hCAFEF00D, 10'h11, 0, 0)};
      tbl[4] = '{1, 1, 32'h20,  32'hA5A5A5A5, 2, 32'h11111111,
                 exp_r(3, 2, 1, 0, 10'h8, 1, 32'hA5A5A5A5)};
      tbl[5] = '{0, 1, 32'h1001, 32'h5, 1, 32'h1, exp_r(1, 0, 1, 0, 0, 0, 0)};
      tbl[6] = '{1, 0, 32'h8,   0, 16, 32'h2222, exp_r(16, 15, 1, 0, 10'h2, 0, 0)};
      tbl[7] = '{1, 0, 32'h100, 0, 0, 32'h5555, exp_r(16, 15, 1, 0, 10'h40, 0, 0)};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.stall",   32'(stall),         0);
      chk("rst.ldValid", 32'(ldValid),       0);
      chk("rst.err",     32'(err),           0);
      chk("rst.req",     32'(bus.mem_req),   0);
      chk("rst.we",      32'(bus.mem_we),    0);
      chk("rst.addr",    32'(bus.mem_addr),  0);
      chk("rst.wdata",   bus.mem_wdata,      0);
      chk("rst.ldres",   ldResult,           0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         run_access(tbl[i].ld, tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].k, tbl[i].rd, r);
         compare($sformatf("vec%0d", i), r, tbl[i].e);
      end

      // Late ack after the timed-out access (tbl[7]) is ignored.
      @(posedge clk); #1;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("late%0d.req", c),   32'(bus.mem_req), 0);
         chk($sformatf("late%0d.valid", c), 32'(ldValid),     0);
         chk($sformatf("late%0d.res", c),   ldResult,         0);
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;

      // Reset during the 2nd REQ cycle drops the request with no completion.
      isLd = 1'b1; aluResult = 32'h40;
      @(posedge clk); #1;          // REQ cycle 1
      @(posedge clk); #1;          // REQ cycle 2
      chk("rstreq.req_before", 32'(bus.mem_req), 1);
      rst = 1'b1; isLd = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("rstreq%0d.req", c),   32'(bus.mem_req), 0);
         chk($sformatf("rstreq%0d.stall", c), 32'(stall),       0);
         chk($sformatf("rstreq%0d.valid", c), 32'(ldValid),     0);
      end
      run_access(1, 0, 32'h80, 0, 2, 32'h0BADF00D, r);
      compare("after_rst", r, model(1, 0, 32'h80, 0, 2, 32'h0BADF00D));

      // Randomized accesses against the reference model.
      for (int n = 0; n < 40; n++) begin
         int sel, k;
         logic [31:0] a, d, rd;
         sel = $urandom_range(1, 3);
         a   = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         d   = $urandom;
         rd  = $urandom;
         k   = $urandom_range(0, TIMEOUT + 2);
         run_access(sel[0], sel[1], a, d, k, rd, r);
         e = model(sel[0], sel[1], a, d, k, rd);
         compare($sformatf("rnd%0d", n), r, e);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
